// File: rtl/approx_mul_err_sweep_ctrl.sv
// Walks an 8x8 approximate multiplier through every operand pair and accumulates
// error statistics (count, sum |ED|, signed bias, max |ED| and where it occurred).
module approx_mul_err_sweep_ctrl #(
   parameter int MUL_LAT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        pause,
   output logic        busy,
   output logic        done,
   output logic [7:0]  mul_x,
   output logic [7:0]  mul_y,
   input  logic [15:0] mul_z,
   output logic [16:0] err_cnt,
   output logic [31:0] sum_abs_err,
   output logic [32:0] sum_err,
   output logic [15:0] max_abs_err,
   output logic [7:0]  max_x,
   output logic [7:0]  max_y
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [2:0] DRAIN_INIT = (MUL_LAT > 0) ? 3'(MUL_LAT - 1) : 3'd0;

   state_t      state, state_nx;
   logic        issue_v;
   logic [2:0]  drain_cnt;
   logic        do_start, do_issue, last_idx;
   logic        acc_v;
   logic [7:0]  acc_x, acc_y;
   logic [15:0] exact, abs_e;
   logic [16:0] diff;

   assign last_idx = ({mul_y, mul_x} == 16'hFFFF);
   assign busy     = (state == RUN) || (state == DRAIN);
   assign done     = (state == DONE);

   // NOTE: every output of this block gets a default before the case, so no path leaves a latch.
   always_comb begin
      state_nx = state;
      do_start = 1'b0;
      do_issue = 1'b0;
      case (state)
         IDLE, DONE: if (start) begin
            state_nx = RUN;
            do_start = 1'b1;
         end
         // index 65535 is issued in the cycle it sits in the operand registers
         RUN: if (last_idx) state_nx = (MUL_LAT == 0) ? DONE : DRAIN;
              else if (!pause) do_issue = 1'b1;
         DRAIN: if (drain_cnt == 3'd0) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
      if (abort) begin
         state_nx = IDLE;
         do_start = 1'b0;
         do_issue = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_v   <= 1'b0;
         mul_x     <= 8'd0;
         mul_y     <= 8'd0;
         drain_cnt <= 3'd0;
      end else begin
         issue_v <= do_start | do_issue;
         if (do_start)      {mul_y, mul_x} <= 16'd0;
         else if (do_issue) {mul_y, mul_x} <= {mul_y, mul_x} + 16'd1;
         if (state == RUN && state_nx == DRAIN)  drain_cnt <= DRAIN_INIT;
         else if (state == DRAIN && drain_cnt != 3'd0) drain_cnt <= drain_cnt - 3'd1;
      end
   end

   generate
      if (MUL_LAT == 0) begin : g_comb
         assign acc_v = issue_v;
         assign acc_x = mul_x;
         assign acc_y = mul_y;
      end else begin : g_pipe
         logic [MUL_LAT-1:0]       v_sr;
         logic [MUL_LAT-1:0][15:0] op_sr;

         always_ff @(posedge clk) begin
            if (rst || abort) v_sr <= '0;
            else begin
               v_sr[0] <= issue_v;
               for (int i = 1; i < MUL_LAT; i++) v_sr[i] <= v_sr[i-1];
            end
         end

         // NOTE: operand stages carry no reset; the valid bit beside them qualifies every use.
         always_ff @(posedge clk) begin
            op_sr[0] <= {mul_y, mul_x};
            for (int i = 1; i < MUL_LAT; i++) op_sr[i] <= op_sr[i-1];
         end

         assign acc_v          = v_sr[MUL_LAT-1];
         assign {acc_y, acc_x} = op_sr[MUL_LAT-1];
      end
   endgenerate

   assign exact = 16'(acc_x) * 16'(acc_y);
   assign diff  = {1'b0, mul_z} - {1'b0, exact};
   assign abs_e = diff[16] ? (exact - mul_z) : (mul_z - exact);

   always_ff @(posedge clk) begin
      if (rst || do_start) begin
         err_cnt     <= 17'd0;
         sum_abs_err <= 32'd0;
         sum_err     <= 33'd0;
         max_abs_err <= 16'd0;
         max_x       <= 8'd0;
         max_y       <= 8'd0;
      end else if (acc_v && !abort) begin
         err_cnt     <= err_cnt + {16'd0, |diff};
         sum_abs_err <= sum_abs_err + {16'd0, abs_e};
         sum_err     <= sum_err + {{16{diff[16]}}, diff};
         // strict compare keeps the earliest pair in sweep order
         if (abs_e > max_abs_err) begin
            max_abs_err <= abs_e;
            max_x       <= acc_x;
            max_y       <= acc_y;
         end
      end
   end

endmodule
